// File: rtl/uart_key_pkg.sv
// Shared constants, key-map table, TX state encoding and helpers for the UART key mapper.
package uart_key_pkg;

  localparam logic [7:0] ESC_BYTE   = 8'h1B;
  localparam logic [7:0] NAK_BYTE   = 8'h3F;
  localparam int         KEY_SHOOT  = 4;
  localparam int         MAX_PLAYER = 4;

  // Row = player, column = w, a, s, d, shoot (lower-case form).
  localparam logic [7:0] KEY_MAP [MAX_PLAYER][5] = '{
    '{8'h77, 8'h61, 8'h73, 8'h64, 8'h20},
    '{8'h69, 8'h6A, 8'h6B, 8'h6C, 8'h75},
    '{8'h38, 8'h34, 8'h35, 8'h36, 8'h30},
    '{8'h74, 8'h66, 8'h67, 8'h68, 8'h72}
  };

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] player;
    logic [2:0] key;
  } key_dec_t;

  function automatic key_dec_t decode_key(input logic [7:0] b);
    logic [7:0] lc;
    key_dec_t   d;
    lc = (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
    d  = '0;
    for (int p = 0; p < MAX_PLAYER; p++) begin
      for (int k = 0; k < 5; k++) begin
        if (!d.hit && lc == KEY_MAP[p][k]) begin
          d.hit    = 1'b1;
          d.player = 2'(p);
          d.key    = 3'(k);
        end
      end
    end
    return d;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/key_hold_timer.sv
// Loadable/clearable down-counter; active while nonzero. Load beats the natural decrement.
module key_hold_timer #(
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_clear,
  output logic o_active
);

  localparam int W = $clog2(HOLD_CYCLES + 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= W'(HOLD_CYCLES);
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_active = (r_count != '0);

endmodule

// File: rtl/uart_key_mapper.sv
// Maps received UART bytes to held per-player direction buttons and shoot pulses,
// and returns one acknowledge byte per received byte through a two-state TX handshake.
module uart_key_mapper #(
  parameter int N_PLAYERS   = 2,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic [N_PLAYERS-1:0] key_en,
  output logic [N_PLAYERS-1:0] bt_w,
  output logic [N_PLAYERS-1:0] bt_a,
  output logic [N_PLAYERS-1:0] bt_s,
  output logic [N_PLAYERS-1:0] bt_d,
  output logic [N_PLAYERS-1:0] bt_st,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [7:0]           bad_cnt,
  output logic [7:0]           drop_cnt
);

  import uart_key_pkg::*;

  key_dec_t   w_dec;
  logic [3:0] w_en4;
  logic       w_esc;
  logic       w_accept;
  logic       w_reject;
  logic [7:0] w_ack_byte;

  assign w_dec      = decode_key(rx_data);
  assign w_en4      = 4'(key_en);   // players >= N_PLAYERS read as disabled
  assign w_esc      = rx_valid && (rx_data == ESC_BYTE);
  assign w_accept   = rx_valid && w_dec.hit && w_en4[w_dec.player];
  assign w_reject   = rx_valid && !w_accept && !w_esc;
  assign w_ack_byte = w_reject ? NAK_BYTE : rx_data;

  logic [N_PLAYERS-1:0][3:0] w_active;
  logic [N_PLAYERS-1:0]      w_shoot;
  logic [N_PLAYERS-1:0]      r_st;

  genvar gi, gk;
  generate
    for (gi = 0; gi < N_PLAYERS; gi++) begin : g_player
      logic w_hit;
      logic w_dir_hit;
      assign w_hit       = w_accept && (w_dec.player == 2'(gi));
      assign w_dir_hit   = w_hit && (w_dec.key != 3'(KEY_SHOOT));
      assign w_shoot[gi] = w_hit && (w_dec.key == 3'(KEY_SHOOT));

      for (gk = 0; gk < 4; gk++) begin : g_dir
        key_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
          .clk      (clk),
          .rst      (rst),
          .i_load   (w_dir_hit && (w_dec.key == 3'(gk))),
          .i_clear  (w_esc || !key_en[gi] || (w_dir_hit && (w_dec.key != 3'(gk)))),
          .o_active (w_active[gi][gk])
        );
      end

      assign bt_w[gi]  = w_active[gi][0];
      assign bt_a[gi]  = w_active[gi][1];
      assign bt_s[gi]  = w_active[gi][2];
      assign bt_d[gi]  = w_active[gi][3];
      assign bt_st[gi] = r_st[gi] && key_en[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_st <= '0;
    else     r_st <= w_shoot;
  end

  tx_state_e  r_state;
  tx_state_e  w_state_next;
  logic       w_take;
  logic       w_drop;
  logic [7:0] r_tx_data;
  logic [7:0] r_bad_cnt;
  logic [7:0] r_drop_cnt;

  // A new ack is only lost when the previous one is still waiting for tx_ready.
  assign w_take = rx_valid && ((r_state == TX_IDLE) || tx_ready);
  assign w_drop = rx_valid && (r_state == TX_SEND) && !tx_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= TX_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      TX_IDLE: if (rx_valid) w_state_next = TX_SEND;
      TX_SEND: if (tx_ready && !rx_valid) w_state_next = TX_IDLE;
      default: w_state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = (r_state == TX_SEND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_data  <= '0;
      r_bad_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_take)   r_tx_data  <= w_ack_byte;
      if (w_reject) r_bad_cnt  <= sat_inc(r_bad_cnt);
      if (w_drop)   r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  assign tx_data  = r_tx_data;
  assign bad_cnt  = r_bad_cnt;
  assign drop_cnt = r_drop_cnt;

endmodule
